// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine.
//   state_e           : FSM state encoding
//   WORD_BYTES        : bytes per memory word
//   MEM_WORDS_DEFAULT : default depth of the target data memory
package mem_copy_engine_pkg;

  localparam int WORD_BYTES        = 4;
  localparam int MEM_WORDS_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_range_check.sv
// Combinational alignment and bounds check for a word-block access.
//   src_addr_i, dst_addr_i : byte addresses of the two regions
//   length_i               : block length in words
//   err_o                  : 1 if either address is misaligned or either
//                            region runs past MEM_WORDS (wrap counts as past)
module mem_copy_range_check
  import mem_copy_engine_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int LEN_W     = 6
) (
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] length_i,
  output logic             err_o
);

  logic [32:0] len_ext;
  logic [32:0] src_end;
  logic [32:0] dst_end;
  logic        misalign;

  // 33-bit sums so a region wrapping past 2^32 can never look in range.
  assign len_ext  = {{(33-LEN_W){1'b0}}, length_i};
  assign src_end  = {3'b000, src_addr_i[31:2]} + len_ext;
  assign dst_end  = {3'b000, dst_addr_i[31:2]} + len_ext;
  assign misalign = (|src_addr_i[1:0]) | (|dst_addr_i[1:0]);

  assign err_o = misalign
               | (src_end > 33'(MEM_WORDS))
               | (dst_end > 33'(MEM_WORDS));

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy engine: second initiator on the data memory port. Copies
// length_i words from src_addr_i to dst_addr_i, one access per cycle
// (read then write per word), ascending order.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i               : command strobe, honoured only in IDLE
//   src/dst_addr_i        : byte addresses, length_i : word count
//   busy_o, done_o        : activity flag, one-cycle completion pulse
//   error_o               : command rejected, held until next accepted start
//   words_done_o          : words written by current/last command
//   mem_*                 : data memory read/write port
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int LEN_W     = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] length_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [LEN_W-1:0] words_done_o,
  output logic [31:0]      mem_addr_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  state_e           state_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [31:0]      buf_q;
  logic [LEN_W-1:0] words_done_q;
  logic             error_q;

  logic             cmd_err;
  logic [LEN_W-1:0] idx_nxt;
  logic [31:0]      idx_bytes;

  mem_copy_range_check #(
    .MEM_WORDS (MEM_WORDS),
    .LEN_W     (LEN_W)
  ) u_range_check (
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .length_i   (length_i),
    .err_o      (cmd_err)
  );

  assign idx_nxt   = idx_q + LEN_W'(1);
  assign idx_bytes = 32'(idx_q) * 32'(WORD_BYTES);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      buf_q        <= '0;
      words_done_q <= '0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            src_q        <= src_addr_i;
            dst_q        <= dst_addr_i;
            len_q        <= length_i;
            idx_q        <= '0;
            words_done_q <= '0;
            error_q      <= cmd_err;
            // Rejected and empty commands both finish without touching memory.
            if (cmd_err || (length_i == '0)) state_q <= ST_DONE;
            else                             state_q <= ST_READ;
          end
        end
        ST_READ: begin
          buf_q   <= mem_rdata_i;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          words_done_q <= words_done_q + LEN_W'(1);
          if (idx_nxt == len_q) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_nxt;
            state_q <= ST_READ;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory port is a pure decode of registered state/index/command, so the
  // address and data are stable for the whole cycle in which write is high.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    case (state_q)
      ST_READ: begin
        mem_addr_o = src_q + idx_bytes;
        mem_read_o = 1'b1;
      end
      ST_WRITE: begin
        mem_addr_o  = dst_q + idx_bytes;
        mem_wdata_o = buf_q;
        mem_write_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign error_o      = error_q;
  assign words_done_o = words_done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

  localparam int MEM_WORDS = 32;
  localparam int LEN_W     = 6;
  localparam int AW        = $clog2(MEM_WORDS);

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [31:0]      src_addr_i;
  logic [31:0]      dst_addr_i;
  logic [LEN_W-1:0] length_i;
  logic             busy_o;
  logic             done_o;
  logic             error_o;
  logic [LEN_W-1:0] words_done_o;
  logic [31:0]      mem_addr_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_i;

  always #5 clk = ~clk;

  mem_copy_engine #(.MEM_WORDS(MEM_WORDS), .LEN_W(LEN_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .src_addr_i   (src_addr_i),
    .dst_addr_i   (dst_addr_i),
    .length_i     (length_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .words_done_o (words_done_o),
    .mem_addr_o   (mem_addr_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  // Data memory model: combinational read, write on the rising edge.
  logic [31:0] mem      [MEM_WORDS];
  logic [31:0] init_mem [MEM_WORDS];
  logic [31:0] ref_mem  [MEM_WORDS];
  logic        load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) mem <= init_mem;
    else if (mem_write_o && (mem_addr_o < 32'(MEM_WORDS*4)))
      mem[mem_addr_o[AW+1:2]] <= mem_wdata_o;
  end

  always_comb begin
    mem_rdata_i = 32'h0;
    if (mem_addr_o < 32'(MEM_WORDS*4)) mem_rdata_i = mem[mem_addr_o[AW+1:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit err;
    int wd;
    int lat;
    int start_cyc;
    int nacc;
  } exp_t;

  exp_t q[$];
  bit   sb_off = 1'b1;

  // Monitor: checks every cycle against the head of the scoreboard.
  bit last_err = 1'b0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;

  always @(negedge clk) begin
    exp_t e;
    int   d;
    int   nbad;
    if (rst_i || sb_off) begin
      last_err = 1'b0;
      rd_cnt   = 0;
      wr_cnt   = 0;
    end else if (q.size() == 0) begin
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_mem_en", {mem_read_o, mem_write_o}, 0);
      chk("idle_error_held", error_o, last_err);
    end else begin
      e = q[0];
      d = cyc - e.start_cyc;
      if (mem_read_o)  rd_cnt++;
      if (mem_write_o) wr_cnt++;
      chk("busy_during_cmd", busy_o, 1);
      if (done_o) begin
        void'(q.pop_front());
        chk("done_latency", d, e.lat);
        chk("done_error", error_o, e.err);
        chk("words_done", words_done_o, e.wd);
        chk("read_count", rd_cnt, e.nacc);
        chk("write_count", wr_cnt, e.nacc);
        nbad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("mem_image_bad_words", nbad, 0);
        last_err = e.err;
        rd_cnt   = 0;
        wr_cnt   = 0;
      end else if (d >= e.lat) begin
        chk("done_missing", done_o, 1);
        void'(q.pop_front());
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Reference model: block-level rules straight from the command semantics.
  function automatic bit ref_err(input logic [31:0] s, input logic [31:0] d, input int len);
    longint sw = longint'(s) / 4;
    longint dw = longint'(d) / 4;
    return (s % 4 != 0) || (d % 4 != 0) ||
           (sw + len > MEM_WORDS) || (dw + len > MEM_WORDS);
  endfunction

  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int len, input bit push);
    exp_t e;
    @(negedge clk);
    src_addr_i = s;
    dst_addr_i = d;
    length_i   = LEN_W'(len);
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (push) begin
      e.err       = ref_err(s, d, len);
      e.wd        = e.err ? 0 : len;
      e.nacc      = e.wd;
      e.lat       = 2 * e.wd;
      e.start_cyc = cyc;
      for (int i = 0; i < e.wd; i++) ref_mem[d/4 + i] = ref_mem[s/4 + i];
      q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("cmd_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic load();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    ref_mem  = init_mem;
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    src_addr_i = '0;
    dst_addr_i = '0;
    length_i   = '0;
    for (int i = 0; i < MEM_WORDS; i++) init_mem[i] = $urandom;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_words_done", words_done_o, 0);
    chk("rst_mem_en", {mem_read_o, mem_write_o}, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    rst_i = 1'b0;

    // Basic copy
    for (int i = 0; i < 4; i++) init_mem[i] = 32'hA0 + 32'(i);
    load();
    sb_off = 1'b0;
    issue(32'h00, 32'h40, 4, 1);
    wait_idle();
    for (int i = 0; i < 4; i++) chk("basic_dst_word", mem[16+i], 32'hA0 + i);

    // Zero length and rejected commands
    issue(32'h00, 32'h40, 0, 1);           wait_idle();
    issue(32'h02, 32'h40, 1, 1);           wait_idle();
    issue(32'h70, 32'h00, 5, 1);           wait_idle();
    issue(32'h00, 32'hFFFF_FFFC, 1, 1);    wait_idle();

    // Overlapping forward copy
    for (int i = 0; i < MEM_WORDS; i++) init_mem[i] = mem[i];
    for (int i = 0; i < 4; i++) init_mem[i] = 32'(i + 1);
    load();
    issue(32'h0, 32'h4, 3, 1);
    wait_idle();
    for (int i = 1; i < 4; i++) chk("overlap_word", mem[i], 1);

    // Second start while busy is ignored
    issue(32'h00, 32'h20, 6, 1);
    repeat (3) @(negedge clk);
    src_addr_i = 32'h40;
    dst_addr_i = 32'h00;
    length_i   = LEN_W'(2);
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle();

    // Reset after the second write of an 8-word copy
    sb_off = 1'b1;
    issue(32'h00, 32'h40, 8, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    ref_mem[16] = ref_mem[0];
    ref_mem[17] = ref_mem[1];
    @(negedge clk);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_error", error_o, 0);
    chk("midrst_words_done", words_done_o, 0);
    chk("midrst_mem_en", {mem_read_o, mem_write_o}, 0);
    chk("midrst_mem_addr", mem_addr_o, 0);
    chk("midrst_mem_wdata", mem_wdata_o, 0);
    begin
      int nbad = 0;
      for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) nbad++;
      chk("midrst_mem_bad_words", nbad, 0);
    end
    @(posedge clk);
    #1;
    sb_off = 1'b0;
    issue(32'h10, 32'h50, 5, 1);
    wait_idle();

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      int          len;
      int          kind;
      logic [31:0] s;
      logic [31:0] d;
      len  = $urandom_range(0, 8);
      kind = $urandom_range(0, 4);
      s    = 32'($urandom_range(0, MEM_WORDS - len)) * 4;
      d    = 32'($urandom_range(0, MEM_WORDS - len)) * 4;
      if (len > 0 && kind == 0) s = s + 32'($urandom_range(1, 3));
      if (len > 0 && kind == 1) d = $urandom & 32'hFFFF_FFFC;
      issue(s, d, len, 1);
      wait_idle();
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
